// File: rtl/tcam7x64_core_if.sv
// rtl/tcam7x64_core_if.sv - request/result bus for the 7-bit-key x 64-entry TCAM core
// Ports (via modports):
//   in_csb, in_web, in_wmask[3:0], in_addr[7:0], in_wdata[31:0], in_mv[63:0] : requester -> core
//   out_rdata[63:0], out_mv[63:0], out_pma[5:0], out_hit                      : core -> requester
interface tcam7x64_core_if;
  logic        in_csb;
  logic        in_web;
  logic [3:0]  in_wmask;
  logic [7:0]  in_addr;
  logic [31:0] in_wdata;
  logic [63:0] in_mv;
  logic [63:0] out_rdata;
  logic [63:0] out_mv;
  logic [5:0]  out_pma;
  logic        out_hit;

  modport master (
    output in_csb, in_web, in_wmask, in_addr, in_wdata, in_mv,
    input  out_rdata, out_mv, out_pma, out_hit
  );

  modport slave (
    input  in_csb, in_web, in_wmask, in_addr, in_wdata, in_mv,
    output out_rdata, out_mv, out_pma, out_hit
  );
endinterface

// File: rtl/tcam7x64_core.sv
// rtl/tcam7x64_core.sv - 7-bit-key x 64-entry TCAM built on a 256x32 byte-writable SRAM
// Ports:
//   in_clk  : rising-edge clock
//   in_rstn : asynchronous active-low reset (clears the match register only)
//   bus     : tcam7x64_core_if.slave (csb/web/wmask/addr/wdata/mv in, rdata/mv/pma/hit out)
// Optional feature: define TCAM7X64_DEBUG_EN to print every operation and search result.
module tcam7x64_core (
  input  logic                 in_clk,
  input  logic                 in_rstn,
  tcam7x64_core_if.slave       bus
);

  // Rows 0..127 carry entries 0..31, rows 128..255 carry entries 32..63.
  logic [31:0] mem_q [0:255];
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] mv;
  logic [5:0]  pma;

  logic       do_write;
  logic       do_search;
  logic [6:0] key;

  assign do_write  = !bus.in_csb && !bus.in_web;
  assign do_search = !bus.in_csb &&  bus.in_web;
  assign key       = bus.in_addr[6:0];

  // Write data lands at this edge, so a search on the next edge already sees it.
  // Writes are suppressed while reset is held so an aborted cycle has no effect.
  always_ff @(posedge in_clk) begin
    if (in_rstn && do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.in_wmask[b]) begin
          mem_q[bus.in_addr][8*b +: 8] <= bus.in_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (do_search) begin
      rdata_d = {mem_q[{1'b1, key}], mem_q[{1'b0, key}]};
    end
  end

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign mv = rdata_q & bus.in_mv;

  // Scan from the top so the lowest set index wins; an empty vector leaves 0.
  always_comb begin
    pma = '0;
    for (int j = 63; j >= 0; j--) begin
      if (mv[j]) begin
        pma = 6'(j);
      end
    end
  end

  assign bus.out_rdata = rdata_q;
  assign bus.out_mv    = mv;
  assign bus.out_pma   = pma;
  assign bus.out_hit   = |mv;

`ifdef TCAM7X64_DEBUG_EN
  logic searched_q;

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      searched_q <= 1'b0;
    end else begin
      searched_q <= do_search;
    end
  end

  always @(posedge in_clk) begin
    if (in_rstn && searched_q) begin
      $display("tcam7x64: result pma=%0d hit=%0b", pma, |mv);
    end
    if (in_rstn && do_write) begin
      $display("tcam7x64: write addr=%02h wmask=%1h wdata=%08h",
               bus.in_addr, bus.in_wmask, bus.in_wdata);
    end
    if (in_rstn && do_search) begin
      $display("tcam7x64: search addr=%02h key=%02h", bus.in_addr, key);
    end
  end
`endif

endmodule

// File: tb/tb_tcam7x64_core.sv
// tb/tb_tcam7x64_core.sv - scoreboard bench for tcam7x64_core
module tb_tcam7x64_core;

  logic in_clk;
  logic in_rstn;

  tcam7x64_core_if bus ();

  tcam7x64_core dut (
    .in_clk  (in_clk),
    .in_rstn (in_rstn),
    .bus     (bus.slave)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [63:0] rd;
    logic [63:0] mvi;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [0:255];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] lowest_set(input logic [63:0] v);
    int i;
    i = 0;
    while (i < 64 && !v[i]) i++;
    return (i == 64) ? 6'd0 : 6'(i);
  endfunction

  task automatic idle();
    bus.in_csb   = 1'b1;
    bus.in_web   = 1'b1;
    bus.in_wmask = 4'h0;
    bus.in_addr  = 8'h00;
    bus.in_wdata = 32'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.in_csb   = 1'b0;
    bus.in_web   = 1'b0;
    bus.in_addr  = a;
    bus.in_wdata = d;
    bus.in_wmask = m;
    for (int b = 0; b < 4; b++)
      if (m[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
    @(posedge in_clk);
    #1;
    idle();
  endtask

  task automatic do_search(input logic [7:0] a, input logic [63:0] mvi);
    exp_t e;
    bus.in_csb  = 1'b0;
    bus.in_web  = 1'b1;
    bus.in_addr = a;
    bus.in_mv   = mvi;
    e.rd  = {mdl[{1'b1, a[6:0]}], mdl[{1'b0, a[6:0]}]};
    e.mvi = mvi;
    sb_q.push_back(e);
    @(posedge in_clk);
    #1;
    idle();
  endtask

  task automatic pop_check(input string tag);
    exp_t        e;
    logic [63:0] emv;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e   = sb_q.pop_front();
    emv = e.rd & e.mvi;
    check({tag, "_rdata"}, bus.out_rdata, e.rd);
    check({tag, "_mv"},    bus.out_mv, emv);
    check({tag, "_pma"},   64'(bus.out_pma), 64'(lowest_set(emv)));
    check({tag, "_hit"},   64'(bus.out_hit), 64'(|emv));
  endtask

  logic [63:0] held;
  logic [7:0]  ra;
  logic [31:0] rd;
  logic [3:0]  rm;

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    idle();
    bus.in_mv = '1;
    in_rstn = 1'b0;
    repeat (2) @(posedge in_clk);
    #1;
    check("reset_rdata", bus.out_rdata, 64'h0);
    check("reset_pma", 64'(bus.out_pma), 64'h0);
    check("reset_hit", 64'(bus.out_hit), 64'h0);
    in_rstn = 1'b1;
    @(posedge in_clk);
    #1;

    // initialize rows that later random searches touch
    for (int k = 16; k < 24; k++) begin
      do_write(8'(k), $urandom, 4'hF);
      do_write(8'(k + 128), $urandom, 4'hF);
    end

    do_write(8'h05, 32'h0000_0010, 4'hF);
    do_write(8'h85, 32'h8000_0000, 4'hF);
    do_search(8'h05, '1);
    pop_check("basic");
    check("basic_const_rdata", bus.out_rdata, 64'h80000000_00000010);
    check("basic_const_pma", 64'(bus.out_pma), 64'd4);

    do_write(8'h05, 32'hFFFF_FFFF, 4'b0010);
    do_search(8'h05, '1);
    pop_check("bytemask");
    check("bytemask_low", {32'h0, bus.out_rdata[31:0]}, 64'h0000FF10);

    do_search(8'h05, ~(64'h1 << 4));
    pop_check("mvmask");
    check("mvmask_pma8", 64'(bus.out_pma), 64'd8);
    bus.in_mv = 64'h0;
    #1;
    check("mvzero_pma", 64'(bus.out_pma), 64'd0);
    check("mvzero_hit", 64'(bus.out_hit), 64'd0);
    check("mvzero_rdata_kept", bus.out_rdata, 64'h80000000_0000FF10);
    bus.in_mv = '1;

    do_search(8'h85, '1);
    pop_check("addr7_ignored");

    // idle cycles with random bus content must not disturb anything
    held = bus.out_rdata;
    for (int c = 0; c < 3; c++) begin
      bus.in_csb   = 1'b1;
      bus.in_web   = 1'($urandom);
      bus.in_addr  = 8'h05;
      bus.in_wdata = $urandom;
      bus.in_wmask = 4'hF;
      @(posedge in_clk);
      #1;
    end
    idle();
    check("csb_hold_rdata", bus.out_rdata, held);
    do_search(8'h05, '1);
    pop_check("csb_mem_kept");

    // random writes each followed immediately by a search of that row
    for (int t = 0; t < 12; t++) begin
      ra = 8'(16 + $urandom_range(0, 7)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      rd = $urandom;
      rm = 4'($urandom);
      do_write(ra, rd, rm);
      do_search(ra ^ 8'h80, {$urandom, $urandom} | 64'h1);
      pop_check("rand_rw");
    end

    // entry 0 vs no match
    do_write(8'h10, 32'h0000_0001, 4'hF);
    do_search(8'h10, 64'h1);
    pop_check("entry0");
    check("entry0_hit", 64'(bus.out_hit), 64'd1);

    // async reset after prior searches, mid-cycle
    #2;
    in_rstn = 1'b0;
    #1;
    check("async_rst_rdata", bus.out_rdata, 64'h0);
    check("async_rst_pma", 64'(bus.out_pma), 64'd0);
    check("async_rst_hit", 64'(bus.out_hit), 64'd0);
    // a search presented while reset is held must not capture
    bus.in_csb  = 1'b0;
    bus.in_web  = 1'b1;
    bus.in_addr = 8'h05;
    @(posedge in_clk);
    #1;
    check("rst_abort_rdata", bus.out_rdata, 64'h0);
    idle();
    in_rstn = 1'b1;
    do_search(8'h05, '1);
    pop_check("post_reset");

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcam7x64_core.md
TCAM7X64_CORE -- requirements
Module: tcam7x64_core

Interface
- REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low. Ports are in_clk and in_rstn.
- REQ-002 in_clk, input, 1: rising-edge clock for all state.
- REQ-003 in_rstn, input, 1: asynchronous active-low reset.
- REQ-004 in_csb, input, 1: active-low chip select; 1 = no operation.
- REQ-005 in_web, input, 1: active-low write enable; 0 = write, 1 = search.
- REQ-006 in_wmask, input, 4: byte enables for a write; bit i covers wdata[8i+7:8i].
- REQ-007 in_addr, input, 8: write row (0..255) on a write; search key in in_addr[6:0] on a search.
- REQ-008 in_wdata, input, 32: write data.
- REQ-009 in_mv, input, 64: incoming match vector from a cascaded block; tie to all-ones when unused.
- REQ-010 out_rdata, output, 64: registered raw match vector of the last search.
- REQ-011 out_mv, output, 64: combinational out_rdata AND in_mv.
- REQ-012 out_pma, output, 6: priority-encoded index of out_mv.
- REQ-013 out_hit, output, 1: OR-reduction of out_mv.

Function
- REQ-014 Storage SHALL be 256 words x 32 bits: rows 0..127 hold entries 0..31 and rows 128..255 hold entries 32..63.
- REQ-015 Write (csb=0, web=0): at the posedge, byte i of mem[in_addr] SHALL be updated only where in_wmask[i]=1. Other bytes SHALL be unchanged. out_rdata SHALL be unchanged.
- REQ-016 Search (csb=0, web=1): at the posedge, out_rdata SHALL load {mem[128+k], mem[k]}, where k = in_addr[6:0]. in_addr[7] SHALL be ignored.
- REQ-017 Search latency SHALL be 1 cycle: the result is visible after the capturing edge and held until the next search or reset.
- REQ-018 csb=1: no memory change; out_rdata SHALL be held.
- REQ-019 A search on the cycle after a write to the same row SHALL return the newly written data.
- REQ-020 out_mv SHALL be the bitwise AND of out_rdata and in_mv. It is combinational, so an in_mv change is visible the same cycle.
- REQ-021 out_pma SHALL be the lowest index j with out_mv[j]=1.
- REQ-022 When out_mv is zero, out_pma SHALL be 0 and out_hit SHALL be 0.
- REQ-023 Entry 0 matching and no match both give pma=0; out_hit SHALL distinguish the two cases.
- REQ-024 Software encodes a ternary entry e by setting bit e in every row k whose key matches the entry pattern. The block does no ternary logic itself.

Reset
- REQ-025 in_rstn=0 SHALL asynchronously clear out_rdata to 0, so out_mv=0, out_pma=0 and out_hit=0.
- REQ-026 Memory contents SHALL NOT be reset (SRAM semantics); they are undefined until written.
- REQ-027 Reset asserted mid-operation SHALL abort any capture on that edge.
- REQ-028 After reset release, the first edge with csb=0 SHALL operate normally.

Configuration
- REQ-029 With macro TCAM7X64_DEBUG_EN defined, each posedge with csb=0 SHALL $display the operation type, in_addr, wmask/wdata (for writes) or key (for searches). The cycle after each search SHALL $display out_pma and out_hit.
- REQ-030 Without TCAM7X64_DEBUG_EN, no display code SHALL be elaborated, and functional behaviour SHALL be identical.

Verification
- REQ-031 Assert in_rstn=0 after prior searches -> out_rdata=0, out_pma=0, out_hit=0 immediately, without waiting for a clock edge.
- REQ-032 Do the following, then search key 0x05 with in_mv all ones -> out_rdata=0x80000000_00000010, out_pma=4, out_hit=1 one cycle later.
  - Write row 0x05 with wdata 0x00000010, wmask F.
  - Write row 0x85 with wdata 0x80000000, wmask F.
- REQ-033 Then write row 0x05 with wdata 0xFFFFFFFF, wmask 4'b0010, and search key 0x05 -> low word 0x0000FF10, out_pma=4.
- REQ-034 Search key 0x05 with in_mv = ~(64'h1<<4) -> lowest set bit of out_mv is bit 8, so out_pma=8, out_hit=1. Then in_mv=0 -> out_pma=0, out_hit=0 in the same cycle.
- REQ-035 Search with in_addr=0x85 -> result identical to key 0x05.
- REQ-036 Hold csb=1 for 3 cycles with random addr/wdata -> out_rdata and memory unchanged.
